// File: rtl/adder_pg_pipeline_stage_if.sv
// Operand-in / generate-propagate-out handshake bundle for adder_pg_pipeline_stage.
// master = upstream/downstream driver side, slave = the stage itself.
interface adder_pg_pipeline_stage_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  sub_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] g_out;
  logic [DATA_WIDTH-1:0] p_out;
  logic                  cin_out;

  modport master (
    output in_valid, a_in, b_in, sub_in, out_ready,
    input  in_ready, out_valid, g_out, p_out, cin_out
  );

  modport slave (
    input  in_valid, a_in, b_in, sub_in, out_ready,
    output in_ready, out_valid, g_out, p_out, cin_out
  );
endinterface

// File: rtl/adder_pg_pipeline_stage.sv
// Registered g/p/cin front-end for the carry-lookahead adder path.
// Define ADDER_PG_SKID_EN for the two-entry skid buffer (registered in_ready); otherwise a single register.
module adder_pg_pipeline_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adder_pg_pipeline_stage_if.slave bus
);

  localparam int NUM_GRP = DATA_WIDTH / 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] p;
    logic                  cin;
  } pg_t;

  if ((DATA_WIDTH % 4) != 0) begin : g_width_chk
    $error("adder_pg_pipeline_stage: DATA_WIDTH must be a multiple of 4");
  end

  // Per-bit g/p, laid out in the 4-bit groups the lookahead network consumes.
  logic [NUM_GRP-1:0][3:0] a_grp, b_grp, g_grp, p_grp;
  pg_t                     pg_in;

  assign a_grp = bus.a_in;
  assign b_grp = bus.b_in;

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp_pg
    logic [3:0] b_eff;
    assign b_eff      = b_grp[gi] ^ {4{bus.sub_in}};
    assign g_grp[gi]  = a_grp[gi] & b_eff;
    assign p_grp[gi]  = a_grp[gi] ^ b_eff;
  end

  assign pg_in.g   = g_grp;
  assign pg_in.p   = p_grp;
  assign pg_in.cin = bus.sub_in;

  pg_t  main_q;
  logic accept;

`ifdef ADDER_PG_SKID_EN
  // Encoding is {skid_valid, main_valid} so both flags are plain state bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;
  pg_t    skid_q;
  logic   load_main_in, load_main_skid, load_skid;

  assign bus.in_ready  = ~state_q[1];
  assign bus.out_valid = state_q[0];
  assign accept        = bus.in_valid & ~state_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && bus.out_ready) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= pg_in;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= pg_in;
    end
  end
`else
  typedef enum logic {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   load_main;

  // Ready passes straight through from downstream in this build.
  assign bus.in_ready  = (state_q == EMPTY) | bus.out_ready;
  assign bus.out_valid = (state_q == ONE);
  assign accept        = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    if (accept) begin
      state_d   = ONE;
      load_main = 1'b1;
    end else if (bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         main_q <= '0;
    else if (load_main) main_q <= pg_in;
  end
`endif

  assign bus.g_out   = main_q.g;
  assign bus.p_out   = main_q.p;
  assign bus.cin_out = main_q.cin;

endmodule

// File: doc/adder_pg_pipeline_stage.md
# adder_pg_pipeline_stage

Registered operand front-end for the 16-bit carry-lookahead adder path. It accepts two operands and an add/subtract select through a valid/ready handshake, and forms the per-bit generate/propagate vectors and the carry-in. It holds them in a pipeline register, so the lookahead carry network and sum logic downstream see stable inputs for a full cycle. By default it carries a two-entry skid buffer, so `in_ready` is fully registered and full throughput is kept under backpressure.

## Interface
- `DATA_WIDTH`, 16, operand width; must be a multiple of 4, matching the 4-bit lookahead grouping.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  upstream operand set valid.
- `in_ready`  output  1  stage can accept an operand set this cycle.
- `a_in`  input  DATA_WIDTH  operand A.
- `b_in`  input  DATA_WIDTH  operand B.
- `sub_in`  input  1  1 = A − B, 0 = A + B.
- `out_valid`  output  1  g/p/cin outputs hold a valid entry.
- `out_ready`  input  1  downstream consumes the entry this cycle.
- `g_out`  output  DATA_WIDTH  per-bit generate, `a & b_eff`.
- `p_out`  output  DATA_WIDTH  per-bit propagate, `a ^ b_eff`. XOR form, so downstream sum = `p ^ carry`.
- `cin_out`  output  1  carry-in to the lookahead network; equals `sub_in`.

## Operation
**Operand handling**
- `b_eff = sub_in ? ~b_in : b_in`.
- g/p/cin are computed combinationally from the inputs and captured only on an accept (`in_valid & in_ready`).
- No arithmetic is performed here. Widths are preserved, and no carry-out or overflow is computed.

**Storage and states**
- Storage is a main register (drives the outputs) and a skid register.
- States are named by (main_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1).

**Transitions**
- EMPTY + accept → ONE; the data goes to main.
- ONE + accept + `out_ready` → ONE; main is replaced by the new data.
- ONE + accept + !`out_ready` → FULL; the new data goes to skid.
- ONE + no accept + `out_ready` → EMPTY.
- FULL + `out_ready` → ONE; skid moves to main and skid becomes empty.
- FULL + !`out_ready` → FULL with no change. `in_ready` is 0, so no accept can happen.

**Outputs and ordering**
- `out_valid` = main_valid.
- `in_ready` = !skid_valid, taken directly from a register.
- Entries leave in strict FIFO order. No entry is dropped or duplicated.
- While `out_valid & !out_ready`, the outputs are held constant.

**Reset**
- Reset asserted at any time, including mid-transfer, clears both entries immediately and asynchronously.
- Reset values: `out_valid`=0, `in_ready`=1, `g_out`=0, `p_out`=0, `cin_out`=0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N, with `out_valid`=1.
- Throughput is one entry per cycle while `out_ready`=1.
- `in_ready` falls in the cycle after the skid fills, and rises in the cycle after the skid drains.
- There is no combinational path from `out_ready` to `in_ready`.
- Simultaneous accept and consume in ONE keeps `out_valid` high with no bubble.
- `in_valid` deasserted while `in_ready`=0 is legal. The stage holds no request state for the input side.

## Configuration
- `ADDER_PG_SKID_EN` defined (default build): two-entry skid buffer as described above.
- `ADDER_PG_SKID_EN` undefined:
  - Only the main register exists.
  - `in_ready = !out_valid | out_ready`, which is combinational from `out_ready`.
  - Latency is still 1 cycle and throughput is still one entry per cycle.
  - The FULL state does not exist.
- Output reset values are the same in both builds.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with FULL occupancy → outputs immediately 0, `in_ready`=1; after release, the first accept appears 1 cycle later.
- **Add:** a=0x00FF, b=0x0001, sub=0, `out_ready`=1 → next cycle g=0x0001, p=0x00FE, cin=0, `out_valid`=1.
- **Subtract:** a=0x0005, b=0x0003, sub=1 → g=0x0004, p=0xFFF9, cin=1. Check the downstream sum = 0x0002.
- **Backpressure:** hold `out_ready`=0 and send three back-to-back sets X, Y, Z with valid held → X and Y accepted, `in_ready`=0 from the cycle after Y, Z stalled. After releasing `out_ready`, X, Y, Z arrive in order on consecutive cycles with no bubbles.
- **Streaming:** 100 random sets with random `out_ready` and `in_valid` → scoreboard matches the g/p/cin reference model, with no loss, duplication or reordering, and outputs stable while stalled.
- **Build variant:** rerun the backpressure test with `ADDER_PG_SKID_EN` undefined → `in_ready` tracks `!out_valid | out_ready` in the same cycle; only X is held while `out_ready`=0.
